// File: rtl/avalon_board_io_slave.sv
// ============================================================================
// Module      : avalon_board_io_slave
// Description : Avalon-MM register slave that exposes DE2 board I/O.
//               ID/scratch registers, LED and 8-digit hex display registers,
//               synchronized switch/key inputs, key press-edge capture (W1C)
//               with a maskable level interrupt. Fixed read latency of one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_board_io_slave #(
    parameter logic [31:0] ID_VALUE  = 32'hDE20_0001,
    parameter int          LED_WIDTH = 18,
    parameter int          SW_WIDTH  = 18,
    parameter int          KEY_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [3:0]           avs_byteenable,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic [KEY_WIDTH-1:0] key,
    output logic [LED_WIDTH-1:0] led,
    output logic [31:0]          hex_digits,
    output logic                 irq
);

    // Word addresses of the register map
    localparam logic [2:0] c_ADDR_ID      = 3'd0;
    localparam logic [2:0] c_ADDR_SCRATCH = 3'd1;
    localparam logic [2:0] c_ADDR_LED     = 3'd2;
    localparam logic [2:0] c_ADDR_HEX     = 3'd3;
    localparam logic [2:0] c_ADDR_SW      = 3'd4;
    localparam logic [2:0] c_ADDR_KEY     = 3'd5;
    localparam logic [2:0] c_ADDR_EDGE    = 3'd6;
    localparam logic [2:0] c_ADDR_MASK    = 3'd7;

    localparam logic [1:0] c_BLANK_DONE   = 2'd3;

    // Synchronizers; keys are inverted before the first stage so that the
    // reset value of every stage means "not pressed".
    logic [SW_WIDTH-1:0]  r_sw_meta;
    logic [SW_WIDTH-1:0]  r_sw_sync;
    logic [KEY_WIDTH-1:0] r_key_meta;
    logic [KEY_WIDTH-1:0] r_key_sync;
    logic [KEY_WIDTH-1:0] r_key_prev;
    logic [1:0]           r_blank_cnt;

    // Software-visible registers
    logic [31:0]          r_scratch;
    logic [LED_WIDTH-1:0] r_led;
    logic [31:0]          r_hex;
    logic [KEY_WIDTH-1:0] r_edge;
    logic [KEY_WIDTH-1:0] r_mask;

    // Read response and interrupt
    logic [31:0]          r_readdata;
    logic                 r_readdatavalid;
    logic                 r_irq;

    // Combinational helpers
    logic [31:0]          w_be_mask;
    logic                 w_blank_done;
    logic [KEY_WIDTH-1:0] w_press;
    logic [KEY_WIDTH-1:0] w_edge_clr;
    logic                 w_wr_scratch;
    logic                 w_wr_led;
    logic                 w_wr_hex;
    logic                 w_wr_edge;
    logic                 w_wr_mask;
    logic [31:0]          w_rdata;

    assign w_be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                        {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};

    assign w_wr_scratch = avs_write && (avs_address == c_ADDR_SCRATCH);
    assign w_wr_led     = avs_write && (avs_address == c_ADDR_LED);
    assign w_wr_hex     = avs_write && (avs_address == c_ADDR_HEX);
    assign w_wr_edge    = avs_write && (avs_address == c_ADDR_EDGE);
    assign w_wr_mask    = avs_write && (avs_address == c_ADDR_MASK);

    // A press is a 0->1 transition of the synchronized pressed level; it is
    // ignored while the post-reset blanking counter is still running so that
    // keys held through reset do not register as new presses.
    assign w_blank_done = (r_blank_cnt == c_BLANK_DONE);
    assign w_press      = r_key_sync & ~r_key_prev & {KEY_WIDTH{w_blank_done}};

    assign w_edge_clr   = w_wr_edge
                        ? (avs_writedata[KEY_WIDTH-1:0] & w_be_mask[KEY_WIDTH-1:0])
                        : '0;

    // Two-stage input synchronizers, edge-detect history stage and blanking counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta   <= '0;
            r_sw_sync   <= '0;
            r_key_meta  <= '0;
            r_key_sync  <= '0;
            r_key_prev  <= '0;
            r_blank_cnt <= '0;
        end else begin
            r_sw_meta   <= sw;
            r_sw_sync   <= r_sw_meta;
            r_key_meta  <= ~key;
            r_key_sync  <= r_key_meta;
            r_key_prev  <= r_key_sync;
            if (!w_blank_done) begin
                r_blank_cnt <= r_blank_cnt + 2'd1;
            end
        end
    end

    // Byte-enabled register writes; a press edge wins over a W1C clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scratch <= '0;
            r_led     <= '0;
            r_hex     <= '0;
            r_edge    <= '0;
            r_mask    <= '0;
        end else begin
            if (w_wr_scratch) begin
                r_scratch <= (r_scratch & ~w_be_mask) | (avs_writedata & w_be_mask);
            end
            if (w_wr_led) begin
                r_led <= (r_led & ~w_be_mask[LED_WIDTH-1:0])
                       | (avs_writedata[LED_WIDTH-1:0] & w_be_mask[LED_WIDTH-1:0]);
            end
            if (w_wr_hex) begin
                r_hex <= (r_hex & ~w_be_mask) | (avs_writedata & w_be_mask);
            end
            if (w_wr_mask) begin
                r_mask <= (r_mask & ~w_be_mask[KEY_WIDTH-1:0])
                        | (avs_writedata[KEY_WIDTH-1:0] & w_be_mask[KEY_WIDTH-1:0]);
            end
            r_edge <= (r_edge & ~w_edge_clr) | w_press;
        end
    end

    // Read mux over the current (pre-write) register contents
    always_comb begin
        w_rdata = '0;
        case (avs_address)
            c_ADDR_ID:      w_rdata = ID_VALUE;
            c_ADDR_SCRATCH: w_rdata = r_scratch;
            c_ADDR_LED:     w_rdata[LED_WIDTH-1:0] = r_led;
            c_ADDR_HEX:     w_rdata = r_hex;
            c_ADDR_SW:      w_rdata[SW_WIDTH-1:0]  = r_sw_sync;
            c_ADDR_KEY:     w_rdata[KEY_WIDTH-1:0] = r_key_sync;
            c_ADDR_EDGE:    w_rdata[KEY_WIDTH-1:0] = r_edge;
            c_ADDR_MASK:    w_rdata[KEY_WIDTH-1:0] = r_mask;
            default:        w_rdata = '0;
        endcase
    end

    // Latency-one read response; data holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= avs_read;
            if (avs_read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    // Registered level interrupt from unmasked captured edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_readdatavalid;
    assign led               = r_led;
    assign hex_digits        = r_hex;
    assign irq               = r_irq;

endmodule

`default_nettype wire
